// File: rtl/wht_pkg.sv
// Shared WHT constants and row word type, used by both the forward feeder and the collector.
package wht_pkg;
  localparam int WIDTH        = 17;
  localparam int SHIFT        = 4;
  localparam int PIXW         = 8;
  localparam int ROWS_PER_BLK = 4;

  typedef logic [4*PIXW-1:0] row_word_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_t;
endpackage

// File: rtl/wht_pix_norm.sv
// One-pixel normaliser: round-to-nearest divide by 2^SHIFT, then clip to an unsigned PIXW range.
module wht_pix_norm #(
  parameter int WIDTH = 17,
  parameter int SHIFT = 4,
  parameter int PIXW  = 8
) (
  input  logic [WIDTH-1:0] pix,
  output logic [PIXW-1:0]  y
);
  localparam logic [WIDTH:0] RND  = (WIDTH+1)'(1 << (SHIFT-1));
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'((1 << PIXW) - 1);

  logic signed [WIDTH:0] sum;
  logic signed [WIDTH:0] shf;

  always_comb begin
    // One guard bit keeps the rounding add from overflowing at full-scale positive input.
    sum = $signed({pix[WIDTH-1], pix} + RND);
    shf = sum >>> SHIFT;
    if (shf[WIDTH]) begin
      y = '0;
    end else if ($unsigned(shf) > MAXV) begin
      y = '1;
    end else begin
      y = shf[PIXW-1:0];
    end
  end
endmodule

// File: rtl/wht_blk_collector.sv
// Collects normalised 4-pixel rows into 4x4 blocks in a two-bank ping-pong buffer and
// streams each block out row by row on a valid/ready interface.
//
// state   | meaning
// RD_IDLE | waiting for the read bank to become full
// RD_SEND | presenting rows 0..3 of the read bank
module wht_blk_collector
  import wht_pkg::*;
#(
  parameter int WIDTH = wht_pkg::WIDTH,
  parameter int SHIFT = wht_pkg::SHIFT,
  parameter int PIXW  = wht_pkg::PIXW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    pix_in0,
  input  logic [WIDTH-1:0]    pix_in1,
  input  logic [WIDTH-1:0]    pix_in2,
  input  logic [WIDTH-1:0]    pix_in3,
  input  logic                pix_ivalid,
  output logic [4*PIXW-1:0]   blk_o,
  output logic                blk_ovalid,
  input  logic                blk_oready,
  output logic                blk_olast,
  output logic [15:0]         blk_cnt,
  output logic                ovf,
  input  logic                ovf_clr
);
  logic [PIXW-1:0]   norm0, norm1, norm2, norm3;
  logic [4*PIXW-1:0] s1_row;
  logic              s1_valid;

  wht_pix_norm #(.WIDTH(WIDTH), .SHIFT(SHIFT), .PIXW(PIXW)) u_norm0 (.pix(pix_in0), .y(norm0));
  wht_pix_norm #(.WIDTH(WIDTH), .SHIFT(SHIFT), .PIXW(PIXW)) u_norm1 (.pix(pix_in1), .y(norm1));
  wht_pix_norm #(.WIDTH(WIDTH), .SHIFT(SHIFT), .PIXW(PIXW)) u_norm2 (.pix(pix_in2), .y(norm2));
  wht_pix_norm #(.WIDTH(WIDTH), .SHIFT(SHIFT), .PIXW(PIXW)) u_norm3 (.pix(pix_in3), .y(norm3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_row   <= '0;
    end else begin
      s1_valid <= pix_ivalid;
      if (pix_ivalid) begin
        s1_row <= {norm3, norm2, norm1, norm0};
      end
    end
  end

  // Write side
  logic [1:0]        wr_row;
  logic              wr_bank;
  logic              wr_drop;
  logic [1:0]        bank_full;
  logic [4*PIXW-1:0] bank_mem [2][ROWS_PER_BLK];
  logic              wr_target_full;
  logic              drop_now;
  logic              wr_en;

  // Read side
  rd_state_t   rd_state, rd_state_nxt;
  logic [1:0]  rd_row;
  logic [1:0]  rd_row_inc;
  logic        rd_bank;
  logic        rd_done;

  assign rd_row_inc = rd_row + 2'd1;
  assign rd_done    = (rd_state == RD_SEND) && blk_ovalid && blk_oready && (rd_row == 2'd3);

  // A bank freed by the final read handshake on this edge is already usable by the writer.
  assign wr_target_full = bank_full[wr_bank] && !(rd_done && (rd_bank == wr_bank));
  assign drop_now       = (wr_row == 2'd0) ? wr_target_full : wr_drop;
  assign wr_en          = s1_valid && !drop_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row    <= 2'd0;
      wr_bank   <= 1'b0;
      wr_drop   <= 1'b0;
      bank_full <= 2'b00;
      ovf       <= 1'b0;
    end else begin
      if (s1_valid) begin
        wr_row <= wr_row + 2'd1;
        if (wr_row == 2'd0) begin
          wr_drop <= wr_target_full;
        end
      end
      if (wr_en && (wr_row == 2'd3)) begin
        wr_bank <= ~wr_bank;
      end
      for (int b = 0; b < 2; b++) begin
        if (wr_en && (wr_row == 2'd3) && (wr_bank == 1'(b))) begin
          bank_full[b] <= 1'b1;
        end else if (rd_done && (rd_bank == 1'(b))) begin
          bank_full[b] <= 1'b0;
        end
      end
      if (s1_valid && (wr_row == 2'd0) && wr_target_full) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_mem[wr_bank][wr_row] <= s1_row;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (bank_full[rd_bank]) rd_state_nxt = RD_SEND;
      RD_SEND: if (rd_done)            rd_state_nxt = RD_IDLE;
      default:                         rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      rd_row     <= 2'd0;
      rd_bank    <= 1'b0;
      blk_o      <= '0;
      blk_ovalid <= 1'b0;
      blk_olast  <= 1'b0;
      blk_cnt    <= 16'd0;
    end else begin
      rd_state <= rd_state_nxt;
      case (rd_state)
        RD_IDLE: begin
          if (bank_full[rd_bank]) begin
            blk_o      <= bank_mem[rd_bank][0];
            blk_ovalid <= 1'b1;
            blk_olast  <= 1'b0;
            rd_row     <= 2'd0;
          end
        end
        RD_SEND: begin
          if (blk_ovalid && blk_oready) begin
            if (rd_row == 2'd3) begin
              blk_ovalid <= 1'b0;
              blk_olast  <= 1'b0;
              rd_row     <= 2'd0;
              rd_bank    <= ~rd_bank;
              blk_cnt    <= blk_cnt + 16'd1;
            end else begin
              blk_o     <= bank_mem[rd_bank][rd_row_inc];
              blk_olast <= (rd_row_inc == 2'd3);
              rd_row    <= rd_row_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wht_blk_collector.sv
// Self-checking bench for wht_blk_collector: table-driven rows plus a scoreboard of expected output rows.
module tb_wht_blk_collector;
  import wht_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [16:0]       pix_in0, pix_in1, pix_in2, pix_in3;
  logic              pix_ivalid;
  row_word_t         blk_o;
  logic              blk_ovalid;
  logic              blk_oready;
  logic              blk_olast;
  logic [15:0]       blk_cnt;
  logic              ovf;
  logic              ovf_clr;

  wht_blk_collector dut (
    .clk(clk), .rst(rst),
    .pix_in0(pix_in0), .pix_in1(pix_in1), .pix_in2(pix_in2), .pix_in3(pix_in3),
    .pix_ivalid(pix_ivalid),
    .blk_o(blk_o), .blk_ovalid(blk_ovalid), .blk_oready(blk_oready),
    .blk_olast(blk_olast), .blk_cnt(blk_cnt), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          p0, p1, p2, p3;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[12];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_cnt  = 0;
  logic        rdy_toggle = 1'b0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_o = '0;
  logic        prev_l = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
  endtask

  function automatic logic [31:0] mk_word(input int v);
    return {8'(v + 48), 8'(v + 32), 8'(v + 16), 8'(v)};
  endfunction

  task automatic send_row(input int p0, input int p1, input int p2, input int p3,
                          input logic [31:0] exp, input logic last, input logic keep);
    exp_t e;
    pix_in0    = 17'(p0);
    pix_in1    = 17'(p1);
    pix_in2    = 17'(p2);
    pix_in3    = 17'(p3);
    pix_ivalid = 1'b1;
    if (keep) begin
      e.word = exp;
      e.last = last;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    pix_ivalid = 1'b0;
  endtask

  task automatic send_gen_block(input int base, input logic keep);
    for (int r = 0; r < 4; r++) begin
      send_row((base + r) * 16, (base + r + 16) * 16, (base + r + 32) * 16, (base + r + 48) * 16,
               mk_word(base + r), (r == 3), keep);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_pending_rows", 32'(sb.size()), 32'd0);
    idle(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_o"},      blk_o,             32'd0);
    check({tag, "_blk_ovalid"}, 32'(blk_ovalid),   32'd0);
    check({tag, "_blk_olast"},  32'(blk_olast),    32'd0);
    check({tag, "_blk_cnt"},    32'(blk_cnt),      32'd0);
    check({tag, "_ovf"},        32'(ovf),          32'd0);
  endtask

  // Output monitor: scoreboard pop on each handshake, and hold check while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          check("stall_valid_held", 32'(blk_ovalid), 32'd1);
          check("stall_data_held",  blk_o,           prev_o);
          check("stall_last_held",  32'(blk_olast),  32'(prev_l));
        end
        if (blk_ovalid && blk_oready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_row: got 0x%08h want no row", blk_o);
          end else begin
            e = sb.pop_front();
            check("row_data", blk_o,          e.word);
            check("row_last", 32'(blk_olast), 32'(e.last));
          end
        end
        prev_v = blk_ovalid;
        prev_r = blk_oready;
        prev_o = blk_o;
        prev_l = blk_olast;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_toggle) blk_oready = ~blk_oready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2048, 2048, 2048, 2048, 32'h80808080};
    tbl[1]  = '{2048, 2048, 2048, 2048, 32'h80808080};
    tbl[2]  = '{2048, 2048, 2048, 2048, 32'h80808080};
    tbl[3]  = '{2048, 2048, 2048, 2048, 32'h80808080};
    tbl[4]  = '{2047, 2039, -100, 4096, 32'hFF007F80};
    tbl[5]  = '{0, 7, 8, -8, 32'h00010000};
    tbl[6]  = '{65535, -65536, 4087, 4088, 32'hFFFF00FF};
    tbl[7]  = '{24, 23, 40, 4079, 32'hFF030102};
    // Reconstructed pixels carry small errors that must round back to the original bytes.
    for (int k = 1; k <= 4; k++) begin
      tbl[7 + k] = '{2048 + 5, 2048 - 3, (k - 1) * 16 + 7, k * 16 - 8,
                     {8'(k), 8'(k - 1), 8'h80, 8'h80}};
    end

    rst        = 1'b1;
    pix_in0    = '0;
    pix_in1    = '0;
    pix_in2    = '0;
    pix_in3    = '0;
    pix_ivalid = 1'b0;
    blk_oready = 1'b1;
    ovf_clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 12; i++) begin
      send_row(tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].p3, tbl[i].exp, (i % 4 == 3), 1'b1);
      if (i % 4 == 3) idle(6);
    end
    drain(100);
    exp_cnt = 3;
    check("table_blk_cnt", 32'(blk_cnt), 32'(exp_cnt));
    check("table_no_ovf", 32'(ovf), 32'd0);

    // Three back-to-back blocks: the third row-0 decision coincides with bank 0 being freed.
    send_gen_block(1, 1'b1);
    send_gen_block(20, 1'b1);
    send_gen_block(40, 1'b1);
    drain(100);
    exp_cnt += 3;
    check("b2b_blk_cnt", 32'(blk_cnt), 32'(exp_cnt));
    check("b2b_no_ovf", 32'(ovf), 32'd0);

    blk_oready = 1'b0;
    send_gen_block(1, 1'b1);
    send_gen_block(5, 1'b1);
    send_gen_block(9, 1'b0);
    idle(4);
    check("ovf_set", 32'(ovf), 32'd1);
    check("stall_blk_cnt", 32'(blk_cnt), 32'(exp_cnt));
    blk_oready = 1'b1;
    drain(100);
    exp_cnt += 2;
    check("ovf_blk_cnt", 32'(blk_cnt), 32'(exp_cnt));
    check("ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    rdy_toggle = 1'b1;
    send_gen_block(50, 1'b1);
    idle(10);
    send_gen_block(60, 1'b1);
    drain(200);
    rdy_toggle = 1'b0;
    blk_oready = 1'b1;
    idle(2);
    exp_cnt += 2;
    check("toggle_blk_cnt", 32'(blk_cnt), 32'(exp_cnt));

    send_row(2048, 2048, 2048, 2048, 32'h80808080, 1'b0, 1'b1);
    send_row(2048, 2048, 2048, 2048, 32'h80808080, 1'b0, 1'b1);
    send_row(2048, 2048, 2048, 2048, 32'h80808080, 1'b0, 1'b1);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    idle(2);
    send_gen_block(70, 1'b1);
    drain(100);
    check("midrst_blk_cnt", 32'(blk_cnt), 32'd1);
    check("midrst_no_ovf", 32'(ovf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
